intr_arb: RTL and testbench

- Unibus interrupt arbiter and sequencer for one BR level.
- Takes level-sensitive intreq/intvec pairs from NDEV devices (pc11, dl11, etc.), raises BR to the CPU and takes the bus grant.
- Picks one winner, runs the SACK/BBSY/INTR vector-transfer handshake, and passes unwanted grants down the daisy chain.
- Sits between the device register modules and the bus pin interface in the zynq design.

---
 rtl/intr_arb_if.sv | 31 +++
 rtl/intr_arb.sv | 229 ++++++++++++++++++++++
 tb/tb_intr_arb.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/intr_arb_if.sv
// Unibus interrupt arbiter bus bundle: device request/vector/ack lines and
// the BR/BG/SACK/BBSY/INTR/SSYN handshake with the vector data bus.
// master = arbiter side, slave = devices plus CPU/bus pin side.
interface intr_arb_if #(
  parameter int NDEV = 4
);
  logic [NDEV-1:0]   intreq;
  logic [8*NDEV-1:0] intvec;
  logic [NDEV-1:0]   intack;
  logic              br_out_h;
  logic              bg_in_h;
  logic              bg_out_h;
  logic              sack_out_h;
  logic              bbsy_in_h;
  logic              bbsy_out_h;
  logic              intr_out_h;
  logic              ssyn_in_h;
  logic [15:0]       d_out_h;

  modport master (
    input  intreq, intvec, bg_in_h, bbsy_in_h, ssyn_in_h,
    output intack, br_out_h, bg_out_h, sack_out_h, bbsy_out_h,
           intr_out_h, d_out_h
  );

  modport slave (
    output intreq, intvec, bg_in_h, bbsy_in_h, ssyn_in_h,
    input  intack, br_out_h, bg_out_h, sack_out_h, bbsy_out_h,
           intr_out_h, d_out_h
  );
endinterface

// File: rtl/intr_arb.sv
// Unibus interrupt arbiter/sequencer for a single BR level.
// Collects device requests, raises BR, takes the grant, runs the
// SACK/BBSY/INTR vector transfer and passes unwanted grants downstream.
// Optional macro INTR_ARB_ROUNDROBIN_EN: rotating priority starting after
// the last acknowledged winner; undefined gives fixed lowest-index priority.
module intr_arb #(
  parameter int NDEV    = 4,
  parameter int DESKEW  = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        init_in_h,
  intr_arb_if.master  bus,
  output logic [31:0] armrdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0]    DESKEW_LD = 4'(DESKEW);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_REQ     = 4'd1;
  localparam logic [3:0] S_GRANTED = 4'd2;
  localparam logic [3:0] S_VECT    = 4'd3;
  localparam logic [3:0] S_WAITSS  = 4'd4;
  localparam logic [3:0] S_DONE    = 4'd5;

  logic [3:0]      state;
  logic            br;
  logic            sack;
  logic            bbsy;
  logic            intr;
  logic [NDEV-1:0] ack;
  logic [2:0]      winner;
  logic [7:0]      vec;
  logic [3:0]      dcnt;
  logic [TW-1:0]   tcnt;
  logic [7:0]      to_count;

  logic            any_req;
  logic [2:0]      sel_idx;
  logic [7:0]      sel_vec;
  logic [NDEV-1:0] winner_onehot;

  assign any_req = |bus.intreq;

`ifdef INTR_ARB_ROUNDROBIN_EN
  logic [2:0] rr_ptr;
  logic       hi_found;
  logic [2:0] hi_idx;
  logic [2:0] lo_idx;

  // Rotating search: first requester at or above the pointer, else wrap to the lowest.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (bus.intreq[i]) begin
        lo_idx = 3'(i);
        if (3'(i) >= rr_ptr) begin
          hi_idx   = 3'(i);
          hi_found = 1'b1;
        end
      end
    end
    sel_idx = hi_found ? hi_idx : lo_idx;
  end

  // Pointer advances past the winner only when its vector was actually accepted.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      rr_ptr <= '0;
    else if (!init_in_h && state == S_WAITSS && bus.ssyn_in_h)
      rr_ptr <= (winner == 3'(NDEV - 1)) ? 3'd0 : winner + 3'd1;
  end
`else
  // Fixed priority: lowest set request index wins.
  always_comb begin
    sel_idx = '0;
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (bus.intreq[i])
        sel_idx = 3'(i);
    end
  end
`endif

  // Vector of the currently selected requester, captured at grant time.
  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (sel_idx == 3'(i))
        sel_vec = bus.intvec[8*i +: 8];
    end
  end

  // One-hot acknowledge pattern for the latched winner.
  always_comb begin
    winner_onehot = '0;
    for (int i = 0; i < NDEV; i++)
      winner_onehot[i] = (winner == 3'(i));
  end

  // Main sequencer; INIT clears the transfer but keeps the timeout statistic.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      br       <= 1'b0;
      sack     <= 1'b0;
      bbsy     <= 1'b0;
      intr     <= 1'b0;
      ack      <= '0;
      winner   <= '0;
      vec      <= '0;
      dcnt     <= DESKEW_LD;
      tcnt     <= '0;
      to_count <= '0;
    end else if (init_in_h) begin
      state  <= S_IDLE;
      br     <= 1'b0;
      sack   <= 1'b0;
      bbsy   <= 1'b0;
      intr   <= 1'b0;
      ack    <= '0;
      winner <= '0;
      dcnt   <= DESKEW_LD;
      tcnt   <= '0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (any_req) begin
            state <= S_REQ;
            br    <= 1'b1;
            dcnt  <= DESKEW_LD;
          end
        end
        S_REQ: begin
          if (!any_req) begin
            state <= S_IDLE;
            br    <= 1'b0;
            dcnt  <= DESKEW_LD;
          end else if (bus.bg_in_h) begin
            winner <= sel_idx;
            vec    <= sel_vec;
            sack   <= 1'b1;
            br     <= 1'b0;
            state  <= S_GRANTED;
            dcnt   <= DESKEW_LD;
          end
        end
        S_GRANTED: begin
          if (bus.bg_in_h || bus.bbsy_in_h) begin
            dcnt <= DESKEW_LD;
          end else if (dcnt <= 4'd1) begin
            bbsy  <= 1'b1;
            sack  <= 1'b0;
            state <= S_VECT;
            dcnt  <= DESKEW_LD;
          end else begin
            dcnt <= dcnt - 4'd1;
          end
        end
        S_VECT: begin
          if (dcnt <= 4'd1) begin
            intr  <= 1'b1;
            state <= S_WAITSS;
            tcnt  <= '0;
            dcnt  <= DESKEW_LD;
          end else begin
            dcnt <= dcnt - 4'd1;
          end
        end
        S_WAITSS: begin
          if (bus.ssyn_in_h) begin
            ack   <= winner_onehot;
            intr  <= 1'b0;
            bbsy  <= 1'b0;
            state <= S_DONE;
            dcnt  <= DESKEW_LD;
          end else if (tcnt == TO_LAST) begin
            intr  <= 1'b0;
            bbsy  <= 1'b0;
            state <= S_DONE;
            dcnt  <= DESKEW_LD;
            if (to_count != 8'hFF)
              to_count <= to_count + 8'd1;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_DONE: begin
          if (bus.ssyn_in_h) begin
            dcnt <= DESKEW_LD;
          end else if (dcnt <= 4'd1) begin
            state <= S_IDLE;
            dcnt  <= DESKEW_LD;
          end else begin
            dcnt <= dcnt - 4'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          br    <= 1'b0;
          sack  <= 1'b0;
          bbsy  <= 1'b0;
          intr  <= 1'b0;
          dcnt  <= DESKEW_LD;
        end
      endcase
    end
  end

  // Grant passes downstream only when we are not claiming it.
  assign bus.bg_out_h = bus.bg_in_h &&
                        ((state == S_IDLE) || (state == S_REQ && !any_req));

  assign bus.br_out_h   = br;
  assign bus.sack_out_h = sack;
  assign bus.bbsy_out_h = bbsy;
  assign bus.intr_out_h = intr;
  assign bus.intack     = ack;
  assign bus.d_out_h    = (state == S_VECT || state == S_WAITSS) ? {8'h00, vec} : 16'h0000;

  assign armrdata = {state, 4'b0000, 1'b0, winner, 4'b0000, to_count, 8'(bus.intreq)};

endmodule

// File: tb/tb_intr_arb.sv
// Self-checking bench for intr_arb (NDEV=4, DESKEW=3, TIMEOUT=20).
// Table-driven request/grant vectors plus hand-written transfer sequences.
module tb_intr_arb;

  logic clk;
  logic rst_n;
  logic init;
  logic [31:0] armrdata;
  int check_count;
  int pass_count;

  intr_arb_if #(.NDEV(4)) bus();

  intr_arb #(.NDEV(4), .DESKEW(3), .TIMEOUT(20)) dut (
    .CLOCK(clk),
    .RESET(rst_n),
    .init_in_h(init),
    .bus(bus),
    .armrdata(armrdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] intreq;
    logic       bg;
    logic       exp_bg_pre;
    logic [3:0] exp_state;
    logic       exp_br;
    logic       exp_bg_post;
    logic       exp_sack;
  } vec_t;

  vec_t vecs[10];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected)
      pass_count++;
    else
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic [3:0] req, input logic bg);
    bus.intreq  = req;
    bus.bg_in_h = bg;
  endtask

  // From GRANTED with the grant still high: release it, run deskews and the vector cycle.
  task automatic finish_transfer(input logic [3:0] exp_ack, input logic [7:0] exp_vec,
                                 input int ss_wait, input string tag);
    bus.bg_in_h   = 1'b0;
    bus.bbsy_in_h = 1'b0;
    tick(); tick();
    check_output({tag, " sack held"}, 32'(bus.sack_out_h), 32'd1);
    check_output({tag, " bbsy early"}, 32'(bus.bbsy_out_h), 32'd0);
    tick();
    check_output({tag, " bbsy up"}, 32'(bus.bbsy_out_h), 32'd1);
    check_output({tag, " sack down"}, 32'(bus.sack_out_h), 32'd0);
    tick(); tick();
    check_output({tag, " intr early"}, 32'(bus.intr_out_h), 32'd0);
    tick();
    check_output({tag, " intr up"}, 32'(bus.intr_out_h), 32'd1);
    check_output({tag, " d_out"}, 32'(bus.d_out_h), {24'd0, exp_vec});
    repeat (ss_wait) tick();
    check_output({tag, " intr held"}, 32'(bus.intr_out_h), 32'd1);
    bus.ssyn_in_h = 1'b1;
    tick();
    check_output({tag, " intack"}, 32'(bus.intack), 32'(exp_ack));
    check_output({tag, " intr drop"}, 32'(bus.intr_out_h), 32'd0);
    check_output({tag, " bbsy drop"}, 32'(bus.bbsy_out_h), 32'd0);
    check_output({tag, " d_out drop"}, 32'(bus.d_out_h), 32'd0);
    bus.ssyn_in_h = 1'b0;
    tick();
    check_output({tag, " intack pulse"}, 32'(bus.intack), 32'd0);
    tick();
    check_output({tag, " done state"}, 32'(armrdata[31:28]), 32'd5);
    tick();
    check_output({tag, " idle state"}, 32'(armrdata[31:28]), 32'd0);
  endtask

  // From IDLE: request, grant, and run until INTR is asserted.
  task automatic reach_waitss(input logic [3:0] req, input string tag);
    apply_stimulus(req, 1'b0);
    tick();
    bus.bg_in_h = 1'b1;
    tick();
    bus.bg_in_h = 1'b0;
    repeat (6) tick();
    check_output({tag, " intr up"}, 32'(bus.intr_out_h), 32'd1);
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    rst_n = 1'b0;
    init  = 1'b0;
    bus.intreq    = 4'b0000;
    bus.intvec    = {8'o074, 8'o070, 8'o064, 8'o060};
    bus.bg_in_h   = 1'b0;
    bus.bbsy_in_h = 1'b0;
    bus.ssyn_in_h = 1'b0;

    // intreq, bg, bg_out before edge, state, br, bg_out after edge, sack
    vecs[0] = '{4'b0000, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'b0100, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{4'b0010, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{4'b0010, 1'b0, 1'b0, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{4'b0000, 1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{4'b0001, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{4'b0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    check_output("reset br", 32'(bus.br_out_h), 32'd0);
    check_output("reset bg_out", 32'(bus.bg_out_h), 32'd0);
    check_output("reset sack", 32'(bus.sack_out_h), 32'd0);
    check_output("reset bbsy", 32'(bus.bbsy_out_h), 32'd0);
    check_output("reset intr", 32'(bus.intr_out_h), 32'd0);
    check_output("reset intack", 32'(bus.intack), 32'd0);
    check_output("reset d_out", 32'(bus.d_out_h), 32'd0);
    check_output("reset armrdata", armrdata, 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] request/grant vector table");
    for (int i = 0; i < 10; i++) begin
      apply_stimulus(vecs[i].intreq, vecs[i].bg);
      #1;
      check_output($sformatf("vec%0d bg_out pre", i), 32'(bus.bg_out_h), 32'(vecs[i].exp_bg_pre));
      tick();
      check_output($sformatf("vec%0d state", i), 32'(armrdata[31:28]), 32'(vecs[i].exp_state));
      check_output($sformatf("vec%0d br", i), 32'(bus.br_out_h), 32'(vecs[i].exp_br));
      check_output($sformatf("vec%0d bg_out post", i), 32'(bus.bg_out_h), 32'(vecs[i].exp_bg_post));
      check_output($sformatf("vec%0d sack", i), 32'(bus.sack_out_h), 32'(vecs[i].exp_sack));
      check_output($sformatf("vec%0d bbsy", i), 32'(bus.bbsy_out_h), 32'd0);
      check_output($sformatf("vec%0d intr", i), 32'(bus.intr_out_h), 32'd0);
    end
    apply_stimulus(4'b0000, 1'b0);
    tick();

    $display("[TB] single request, device 2");
    apply_stimulus(4'b0100, 1'b0);
    tick();
    check_output("single br up", 32'(bus.br_out_h), 32'd1);
    repeat (4) tick();
    check_output("single br held", 32'(bus.br_out_h), 32'd1);
    bus.bg_in_h = 1'b1;
    tick();
    check_output("single br drop", 32'(bus.br_out_h), 32'd0);
    check_output("single sack", 32'(bus.sack_out_h), 32'd1);
    check_output("single bg_out blocked", 32'(bus.bg_out_h), 32'd0);
    check_output("single winner", 32'(armrdata[23:20]), 32'd2);
    finish_transfer(4'b0100, 8'o070, 9, "single");
    bus.intreq = 4'b0000;
    tick();
    check_output("single stays idle", 32'(armrdata[31:28]), 32'd0);

    $display("[TB] simultaneous requests 1010");
    apply_stimulus(4'b1010, 1'b0);
    tick();
    bus.bg_in_h = 1'b1;
    tick();
    check_output("simul winner", 32'(armrdata[23:20]), 32'd1);
    bus.intvec[15:8] = 8'o111;
    bus.intreq       = 4'b1000;
    finish_transfer(4'b0010, 8'o064, 2, "simul first");
    bus.intvec[15:8] = 8'o064;
    bus.intreq       = 4'b1010;
    tick();
    bus.bg_in_h = 1'b1;
    tick();
`ifdef INTR_ARB_ROUNDROBIN_EN
    check_output("rearb winner", 32'(armrdata[23:20]), 32'd3);
    finish_transfer(4'b1000, 8'o074, 2, "rearb");
`else
    check_output("rearb winner", 32'(armrdata[23:20]), 32'd1);
    finish_transfer(4'b0010, 8'o064, 2, "rearb");
`endif
    bus.intreq = 4'b0000;
    tick();

    $display("[TB] ssyn timeout");
    reach_waitss(4'b0001, "timeout");
    repeat (19) tick();
    check_output("timeout intr held", 32'(bus.intr_out_h), 32'd1);
    tick();
    check_output("timeout intr drop", 32'(bus.intr_out_h), 32'd0);
    check_output("timeout bbsy drop", 32'(bus.bbsy_out_h), 32'd0);
    check_output("timeout d_out drop", 32'(bus.d_out_h), 32'd0);
    check_output("timeout intack", 32'(bus.intack), 32'd0);
    check_output("timeout state", 32'(armrdata[31:28]), 32'd5);
    check_output("timeout count", 32'(armrdata[15:8]), 32'd1);
    bus.intreq = 4'b0000;
    tick();
    check_output("timeout intack after", 32'(bus.intack), 32'd0);
    tick(); tick();
    check_output("timeout back idle", 32'(armrdata[31:28]), 32'd0);

    $display("[TB] init during WAITSS");
    reach_waitss(4'b0100, "init");
    repeat (3) tick();
    init = 1'b1;
    tick();
    check_output("init intr", 32'(bus.intr_out_h), 32'd0);
    check_output("init bbsy", 32'(bus.bbsy_out_h), 32'd0);
    check_output("init d_out", 32'(bus.d_out_h), 32'd0);
    check_output("init intack", 32'(bus.intack), 32'd0);
    check_output("init state", 32'(armrdata[31:28]), 32'd0);
    check_output("init keeps count", 32'(armrdata[15:8]), 32'd1);
    init = 1'b0;
    bus.intreq = 4'b0000;
    tick();
    check_output("init intack after", 32'(bus.intack), 32'd0);

    $display("[TB] async reset in GRANTED");
    apply_stimulus(4'b0001, 1'b0);
    tick();
    bus.bg_in_h = 1'b1;
    tick();
    check_output("arst sack before", 32'(bus.sack_out_h), 32'd1);
    rst_n = 1'b0;
    #2;
    check_output("arst sack", 32'(bus.sack_out_h), 32'd0);
    check_output("arst br", 32'(bus.br_out_h), 32'd0);
    check_output("arst state", 32'(armrdata[31:28]), 32'd0);
    check_output("arst count", 32'(armrdata[15:8]), 32'd0);
    apply_stimulus(4'b0000, 1'b0);
    rst_n = 1'b1;
    tick();
    check_output("arst idle", 32'(armrdata[31:28]), 32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
